mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative multiply/divide unit with HI/LO registers for the MIPS datapath; the sequential companion to the combinational ALU.
//  Executes MULT/MULTU/DIV/DIVU over WIDTH+2 clocks with a start/busy/done handshake, and MTHI/MTLO in one clock.
//  Sits beside the ALU in EX; the pipeline stalls on busy and reads hi/lo for MFHI/MFLO.
// PARAMETERS
//  WIDTH  32  operand width; hi/lo are each WIDTH bits, product is 2*WIDTH bits
// PORTS
//  clk     in   1      clock, rising edge
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      launch op; sampled only when busy=0
//  op      in   3      MDU_MULT=0 MULTU=1 DIV=2 DIVU=3 MTHI=4 MTLO=5; 6,7 reserved (ignored)
//  a       in   WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source)
//  b       in   WIDTH  rt operand (multiplier/divisor)
//  cancel  in   1      synchronous abort (exception flush); hi/lo keep old values
//  busy    out  1      op in flight; start ignored while high
//  done    out  1      one-cycle pulse: hi/lo now hold the result
//  div0    out  1      valid with done: last DIV/DIVU had b==0
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, div0=0, hi=0, lo=0, counter=0.
//  States: IDLE, CALC, FIX.
//   IDLE & start & op in {MULT,MULTU,DIV,DIVU}: latch |a|,|b| (magnitudes if signed op; raw if unsigned),
//     result signs, op; counter=WIDTH-1; -> CALC; busy=1. DIV/DIVU with b==0 -> FIX directly.
//   IDLE & start & MTHI/MTLO: hi<=a / lo<=a at that edge; no busy, no done.
//   CALC: one bit per clock. MUL: shift-add radix-2 on 2*WIDTH accumulator.
//     DIV: restoring shift-subtract; remainder WIDTH+1 bits, quotient shifts in from LSB.
//     counter==0 -> FIX, else counter-1.
//   FIX: apply signs, write hi/lo, -> IDLE; busy=0 and done=1 for the following cycle.
//  Latency: start edge = edge 0; hi/lo written and done raised at edge WIDTH+1 (total WIDTH+2 clocks incl. FIX);
//    busy high from edge 0 through that edge. Div-by-zero: written at edge 1.
//  Results: MULT/MULTU {hi,lo}=a*b (signed/unsigned, full 2*WIDTH bits).
//    DIV/DIVU lo=quotient truncated toward zero, hi=remainder with sign of dividend.
//    DIV overflow MIN/-1: lo=MIN (0x80000000 at 32), hi=0; no flag.
//    b==0: lo=all ones, hi=a, div0=1 with done. div0 cleared on next accepted start.
//  Never raises arithmetic overflow; no trap.
//  cancel: in CALC/FIX -> IDLE next edge, busy=0, no done, hi/lo unchanged. In IDLE it blocks start that cycle.
//  start while busy: ignored (no queueing). done and start may coincide: new op accepted in the done cycle.
//  Reset mid-operation: all state returns to reset values immediately; no done.
// STRUCTURE
//  Shared package mdu_pkg: op encodings MDU_MULT..MDU_MTLO, state encoding, localparam for counter width $clog2(WIDTH).
//  One sub-module: mdu_div_core (one restoring-division step, combinational: rem,quo,divisor -> next rem,quo);
//    multiplier step, sign fix and FSM stay in mul_div_unit.
// TESTING
//  MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at edge 33: hi=0xFFFFFFFE lo=0x00000001; busy high 33 edges.
//  MULT a=-7 b=3 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//  DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0; DIVU a=100 b=0 -> done at edge 1, div0=1, lo=0xFFFFFFFF hi=100.
//  MTHI a=0x1234 then MTLO a=0x5678 back-to-back -> hi=0x1234 lo=0x5678, busy/done never assert.
//  DIVU 100/7 started, cancel at edge 10 -> busy=0, no done, hi/lo hold prior values; start during busy ignored.
//  rst_n low mid-MULT -> all outputs 0 asynchronously; new MULT after release completes with correct result.

Source files
------------

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
//   Shared definitions for the iterative multiply/divide unit: operation
//   encodings as seen on the op port, FSM state encoding and the default
//   operand width with its iteration-counter width.
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

    // Encodings 6 and 7 are reserved; a start carrying them is ignored.
    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// -----------------------------------------------------------------------------
// mdu_div_core
//   One step of restoring division, purely combinational. The partial
//   remainder is shifted left by one, pulling in the next dividend bit from
//   the MSB of the quotient register; the divisor is trial-subtracted and the
//   result kept only if it did not borrow. The quotient register shifts left
//   and receives the new quotient bit at its LSB.
// Ports
//   rem_i      [WIDTH:0]    current partial remainder
//   quo_i      [WIDTH-1:0]  quotient register (remaining dividend bits on top)
//   divisor_i  [WIDTH-1:0]  divisor magnitude
//   rem_o      [WIDTH:0]    next partial remainder
//   quo_o      [WIDTH-1:0]  next quotient register
// -----------------------------------------------------------------------------
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {2'b00, divisor_i};
        // A set top bit means the trial subtraction went negative: restore.
        borrow  = diff[WIDTH+1];
        rem_o   = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
        quo_o   = {quo_i[WIDTH-2:0], ~borrow};
    end

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Iterative multiply/divide unit with HI/LO registers for the MIPS EX stage.
//   MULT/MULTU/DIV/DIVU run on operand magnitudes, one bit per clock, then a
//   FIX cycle applies the result signs and writes HI/LO. MTHI/MTLO write in
//   the same edge that accepts them and never raise busy or done.
// Ports
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   launch op; sampled only while busy is low
//   op      in   [2:0] operation (mdu_op_e), 6/7 ignored
//   a       in   [WIDTH-1:0] rs operand (multiplicand/dividend, MTHI/MTLO data)
//   b       in   [WIDTH-1:0] rt operand (multiplier/divisor)
//   cancel  in   synchronous abort; HI/LO keep their values
//   busy    out  operation in flight
//   done    out  one-cycle pulse, HI/LO now hold the result
//   div0    out  last DIV/DIVU had a zero divisor (meaningful with done)
//   hi      out  [WIDTH-1:0] HI register
//   lo      out  [WIDTH-1:0] LO register
// -----------------------------------------------------------------------------
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc_hi: product upper half (MUL) or partial remainder (DIV).
    // acc_lo: multiplier shifting out (MUL) or dividend/quotient (DIV).
    // opnd:   multiplicand (MUL) or divisor (DIV) magnitude.
    logic [WIDTH:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             mul_q, mul_d;     // 1: multiply in flight, 0: divide
    logic             neg_q, neg_d;     // product/quotient must be negated
    logic             rneg_q, rneg_d;   // remainder must be negated
    logic             dz_q, dz_d;       // divide by zero in flight
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;

    // Start-time operand conditioning.
    logic             op_signed;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Multiplier step: add multiplicand when the current multiplier bit is
    // set, then shift the whole 2*WIDTH accumulator right by one.
    logic [WIDTH:0]   mul_sum;

    // Divider step.
    logic [WIDTH:0]   div_rem;
    logic [WIDTH-1:0] div_quo;

    // Sign fix-up.
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    mdu_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .rem_i    (acc_hi_q),
        .quo_i    (acc_lo_q),
        .divisor_i(opnd_q),
        .rem_o    (div_rem),
        .quo_o    (div_quo)
    );

    always_comb begin
        op_signed = (op == MDU_MULT) || (op == MDU_DIV);
        a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

        mul_sum   = {1'b0, acc_hi_q[WIDTH-1:0]}
                  + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

        prod_raw  = {acc_hi_q[WIDTH-1:0], acc_lo_q};
        prod_fix  = neg_q  ? -prod_raw            : prod_raw;
        quo_fix   = neg_q  ? -acc_lo_q            : acc_lo_q;
        rem_fix   = rneg_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        mul_d    = mul_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        div0_d   = div0_q;

        unique case (state_q)
            MDU_IDLE: begin
                // cancel in IDLE suppresses the start of that cycle.
                if (start && !cancel) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            div0_d   = 1'b0;
                            mul_d    = 1'b1;
                            dz_d     = 1'b0;
                            acc_hi_d = '0;
                            acc_lo_d = b_mag;
                            opnd_d   = a_mag;
                            neg_d    = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            rneg_d   = 1'b0;
                            cnt_d    = CNT_W'(WIDTH - 1);
                            state_d  = MDU_CALC;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            div0_d   = 1'b0;
                            mul_d    = 1'b0;
                            acc_hi_d = '0;
                            acc_lo_d = a_mag;
                            opnd_d   = b_mag;
                            neg_d    = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            rneg_d   = op_signed && a[WIDTH-1];
                            cnt_d    = CNT_W'(WIDTH - 1);
                            if (b == '0) begin
                                // Skip the iterations; FIX returns the raw
                                // dividend in HI, so keep it unconditioned.
                                dz_d     = 1'b1;
                                acc_lo_d = a;
                                state_d  = MDU_FIX;
                            end else begin
                                dz_d     = 1'b0;
                                state_d  = MDU_CALC;
                            end
                        end
                        MDU_MTHI: begin
                            div0_d = 1'b0;
                            hi_d   = a;
                        end
                        MDU_MTLO: begin
                            div0_d = 1'b0;
                            lo_d   = a;
                        end
                        default: ;
                    endcase
                end
            end

            MDU_CALC: begin
                if (cancel) begin
                    state_d = MDU_IDLE;
                end else begin
                    if (mul_q) begin
                        acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end else begin
                        acc_hi_d = div_rem;
                        acc_lo_d = div_quo;
                    end
                    if (cnt_q == '0) begin
                        state_d = MDU_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            MDU_FIX: begin
                state_d = MDU_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        hi_d   = acc_lo_q;
                        lo_d   = '1;
                        div0_d = 1'b1;
                    end else if (mul_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end

            default: state_d = MDU_IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset along with the control state;
    // they are few and a known value after reset keeps HI/LO deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            mul_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            mul_q    <= mul_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    assign busy = (state_q != MDU_IDLE);
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed bench for mul_div_unit (WIDTH=32) with hand-computed results.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    mul_div_unit #(
        .WIDTH(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cancel(cancel),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launches one op (b2b=1: drive start in the current falling-edge slot,
    // e.g. the done cycle of the previous op), counts edges to done and
    // checks the result, busy duration and the single-cycle done pulse.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input int exp_edges, input bit b2b);
        int edges;
        int busy_cnt;
        if (!b2b) @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);                     // edge 0
        @(negedge clk);
        start    = 1'b0;
        edges    = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check({tag, "_edges"}, 64'(edges), 64'(exp_edges));
        check({tag, "_busy_edges"}, 64'(busy_cnt), 64'(exp_edges));
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_div0"}, 64'(div0), 64'(exp_dz));
    endtask

    initial begin
        int seen_done;

        rst_n  = 1'b0;
        start  = 1'b0;
        op     = '0;
        a      = '0;
        b      = '0;
        cancel = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div0", 64'(div0), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        rst_n = 1'b1;

        // Multiplies, full latency WIDTH+1 edges after the start edge.
        run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 1'b0);
        @(negedge clk);
        check("multu_max_done_pulse", 64'(done), 64'd0);
        run_op("mult_neg", MDU_MULT, 32'hFFFF_FFF9, 32'd3,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1'b0);
        run_op("mult_pos_neg", MDU_MULT, 32'd5, 32'hFFFF_FFFC,
               32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b0, 33, 1'b0);
        run_op("multu_mid", MDU_MULTU, 32'h1234_5678, 32'h10,
               32'h0000_0001, 32'h2345_6780, 1'b0, 33, 1'b0);

        // Divides.
        run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);
        run_op("div_pos_neg", MDU_DIV, 32'd7, 32'hFFFF_FFFE,
               32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 1'b0, 33, 1'b0);
        run_op("divu_zero", MDU_DIVU, 32'd100, 32'd0,
               32'd100, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
        // New op accepted in the done cycle; div0 clears.
        run_op("divu_b2b", MDU_DIVU, 32'd100, 32'd7,
               32'd2, 32'd14, 1'b0, 33, 1'b1);

        // Reserved encoding is ignored.
        @(negedge clk);
        start = 1'b1;
        op    = 3'd6;
        a     = 32'hAAAA_AAAA;
        @(negedge clk);
        start = 1'b0;
        check("rsvd_busy", 64'(busy), 64'd0);
        check("rsvd_hi",   64'(hi),   64'd2);

        // MTHI then MTLO back to back.
        @(negedge clk);
        start = 1'b1;
        op    = MDU_MTHI;
        a     = 32'h1234;
        @(negedge clk);
        check("mthi_hi",   64'(hi),   64'h1234);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_done", 64'(done), 64'd0);
        op = MDU_MTLO;
        a  = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo",   64'(lo),   64'h5678);
        check("mtlo_hi",   64'(hi),   64'h1234);
        check("mtlo_busy", 64'(busy), 64'd0);
        check("mtlo_done", 64'(done), 64'd0);

        // cancel in IDLE blocks a start.
        start  = 1'b1;
        cancel = 1'b1;
        op     = MDU_MTHI;
        a      = 32'hBEEF;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        check("idle_cancel_hi", 64'(hi), 64'h1234);

        // DIVU 100/7 with an ignored start while busy, cancelled at edge 10.
        start = 1'b1;
        op    = MDU_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);                     // edge 0
        @(negedge clk);
        start = 1'b0;
        check("cancel_busy_start", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);          // after edge 2
        start = 1'b1;
        op    = MDU_MTHI;
        a     = 32'hDEAD;
        @(negedge clk);                     // after edge 3
        start = 1'b0;
        check("busy_start_ignored_hi", 64'(hi), 64'h1234);
        repeat (6) @(negedge clk);          // after edge 9
        cancel = 1'b1;
        @(negedge clk);                     // after edge 10
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_done", 64'(done), 64'd0);
        check("cancel_hi",   64'(hi),   64'h1234);
        check("cancel_lo",   64'(lo),   64'h5678);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        check("cancel_no_done", 64'(seen_done), 64'd0);
        check("cancel_lo_late", 64'(lo), 64'h5678);

        // Asynchronous reset mid-MULT, then a clean MULT.
        start = 1'b1;
        op    = MDU_MULT;
        a     = 32'd9;
        b     = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi",   64'(hi),   64'd0);
        check("arst_lo",   64'(lo),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("arst_no_done", 64'(seen_done), 64'd0);
        run_op("mult_after_rst", MDU_MULT, 32'hFFFF_FFF9, 32'd3,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
